// File: rtl/text_glyph_renderer_if.sv
// rtl/text_glyph_renderer_if.sv - register-side write port bundle for text_glyph_renderer
interface text_glyph_renderer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_col;
  logic [4:0] wr_row;
  logic [7:0] wr_char;
  logic [7:0] wr_attr;
  logic       wr_err;

  modport master (output wr_valid, wr_col, wr_row, wr_char, wr_attr,
                  input  wr_ready, wr_err);
  modport slave  (input  wr_valid, wr_col, wr_row, wr_char, wr_attr,
                  output wr_ready, wr_err);
endinterface

// File: rtl/text_glyph_renderer.sv
// rtl/text_glyph_renderer.sv - text buffer + 3-stage glyph pixel pipeline (optional cursor: CURSOR_BLINK_EN)
module text_glyph_renderer #(
  parameter int         COLS     = 80,
  parameter int         ROWS     = 30,
  parameter int         GLYPH_W  = 8,
  parameter int         GLYPH_H  = 16,
  parameter logic [7:0] CLR_ATTR = 8'h07
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  text_glyph_renderer_if.slave        wr,
  input  logic                        clr_start,
  output logic                        clr_busy,
  input  logic [9:0]                  pix_x,
  input  logic [9:0]                  pix_y,
  input  logic                        pix_active,
  input  logic                        pix_hsync,
  input  logic                        pix_vsync,
  output logic [11:0]                 rom_addr,
  input  logic [7:0]                  rom_data,
  input  logic [6:0]                  cur_col,
  input  logic [4:0]                  cur_row,
  output logic [11:0]                 rgb_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        active_out
);

  localparam int                DEPTH = COLS * ROWS;
  localparam int                AW    = $clog2(DEPTH);
  localparam int                XB    = $clog2(GLYPH_W);
  localparam int                YB    = $clog2(GLYPH_H);
  localparam logic [AW-1:0]     LAST  = AW'(DEPTH - 1);
  localparam logic [9:0]        TXT_W = 10'(COLS * GLYPH_W);
  localparam logic [9:0]        TXT_H = 10'(ROWS * GLYPH_H);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          wr_err_q, wr_err_d;
  logic          wr_ready_c;
  logic          wr_in_range;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem [DEPTH];

  // pixel pipeline state
  logic          pix_in_area;
  logic [AW-1:0] rd_addr;
  logic [15:0]   buf_q, buf_d;
  logic [3:0]    s1_yrow_q, s1_yrow_d;
  logic [2:0]    s1_xbit_q, s1_xbit_d;
  logic          s1_area_q, s1_area_d, s1_act_q, s1_act_d;
  logic          s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
  logic [7:0]    s2_attr_q, s2_attr_d;
  logic [2:0]    s2_xbit_q, s2_xbit_d;
  logic          s2_area_q, s2_area_d, s2_act_q, s2_act_d;
  logic          s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          hs_q, hs_d, vs_q, vs_d, act_q, act_d;
  logic          force_glyph;
  logic [7:0]    glyph;
  logic          pix_bit;
  logic [3:0]    pal_idx;

  function automatic logic [11:0] palette(input logic [3:0] idx);
    case (idx)
      4'h0: palette = 12'h000;  4'h1: palette = 12'h00A;
      4'h2: palette = 12'h0A0;  4'h3: palette = 12'h0AA;
      4'h4: palette = 12'hA00;  4'h5: palette = 12'hA0A;
      4'h6: palette = 12'hA50;  4'h7: palette = 12'hAAA;
      4'h8: palette = 12'h555;  4'h9: palette = 12'h55F;
      4'hA: palette = 12'h5F5;  4'hB: palette = 12'h5FF;
      4'hC: palette = 12'hF55;  4'hD: palette = 12'hF5F;
      4'hE: palette = 12'hFF5;  default: palette = 12'hFFF;
    endcase
  endfunction

  assign wr_in_range = (32'(wr.wr_col) < COLS) && (32'(wr.wr_row) < ROWS);

  // Write-side FSM: register writes in IDLE, one blank cell per cycle in CLEAR
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wr_err_d   = 1'b0;
    wr_ready_c = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        wr_ready_c = !clr_start;
        if (clr_start) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (wr.wr_valid) begin
          if (wr_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = AW'(wr.wr_row) * AW'(COLS) + AW'(wr.wr_col);
            mem_wdata = {wr.wr_char, wr.wr_attr};
          end else begin
            wr_err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = {8'h20, CLR_ATTR};
        if (ptr_q == LAST) state_d = IDLE;
        else               ptr_d   = ptr_q + AW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-side state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Text buffer write port; contents deliberately survive reset
  always_ff @(posedge ACLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign wr.wr_ready = wr_ready_c && !ARESET;
  assign wr.wr_err   = wr_err_q;
  assign clr_busy    = (state_q == CLEAR);

  // Pixel stage logic: cell lookup, ROM bit select and palette mapping
  always_comb begin
    pix_in_area = (pix_x < TXT_W) && (pix_y < TXT_H);
    rd_addr     = '0;
    if (pix_in_area) rd_addr = AW'(pix_y >> YB) * AW'(COLS) + AW'(pix_x >> XB);
    buf_d     = mem[rd_addr];
    s1_yrow_d = pix_y[3:0];
    s1_xbit_d = pix_x[2:0];
    s1_area_d = pix_in_area;
    s1_act_d  = pix_active;
    s1_hs_d   = pix_hsync;
    s1_vs_d   = pix_vsync;

    s2_attr_d = buf_q[7:0];
    s2_xbit_d = s1_xbit_q;
    s2_area_d = s1_area_q;
    s2_act_d  = s1_act_q;
    s2_hs_d   = s1_hs_q;
    s2_vs_d   = s1_vs_q;

    glyph   = force_glyph ? 8'hFF : rom_data;
    pix_bit = glyph[3'd7 - s2_xbit_q];
    pal_idx = pix_bit ? s2_attr_q[3:0] : s2_attr_q[7:4];
    rgb_d   = (s2_act_q && s2_area_q) ? palette(pal_idx) : 12'h000;
    hs_d    = s2_hs_q;
    vs_d    = s2_vs_q;
    act_d   = s2_act_q;
  end

  // Pixel pipeline registers (buffer read data is the C1 register)
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      buf_q <= '0; s1_yrow_q <= '0; s1_xbit_q <= '0;
      s1_area_q <= 1'b0; s1_act_q <= 1'b0; s1_hs_q <= 1'b0; s1_vs_q <= 1'b0;
      s2_attr_q <= '0; s2_xbit_q <= '0;
      s2_area_q <= 1'b0; s2_act_q <= 1'b0; s2_hs_q <= 1'b0; s2_vs_q <= 1'b0;
      rgb_q <= '0; hs_q <= 1'b0; vs_q <= 1'b0; act_q <= 1'b0;
    end else begin
      buf_q <= buf_d; s1_yrow_q <= s1_yrow_d; s1_xbit_q <= s1_xbit_d;
      s1_area_q <= s1_area_d; s1_act_q <= s1_act_d; s1_hs_q <= s1_hs_d; s1_vs_q <= s1_vs_d;
      s2_attr_q <= s2_attr_d; s2_xbit_q <= s2_xbit_d;
      s2_area_q <= s2_area_d; s2_act_q <= s2_act_d; s2_hs_q <= s2_hs_d; s2_vs_q <= s2_vs_d;
      rgb_q <= rgb_d; hs_q <= hs_d; vs_q <= vs_d; act_q <= act_d;
    end
  end

`ifdef CURSOR_BLINK_EN
  logic [4:0] frame_q, frame_d;
  logic       s1_cur_q, s1_cur_d;
  logic       s2_cur_q, s2_cur_d;

  // Frame count on vsync rising edge; cursor hit tracked alongside the pixel
  always_comb begin
    frame_d  = frame_q + 5'((pix_vsync && !s1_vs_q) ? 1 : 0);
    s1_cur_d = ((pix_x >> XB) == 10'(cur_col)) && ((pix_y >> YB) == 10'(cur_row));
    s2_cur_d = s1_cur_q && frame_q[4] && (s1_yrow_q >= 4'(GLYPH_H - 2));
  end

  // Cursor state registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      frame_q  <= '0;
      s1_cur_q <= 1'b0;
      s2_cur_q <= 1'b0;
    end else begin
      frame_q  <= frame_d;
      s1_cur_q <= s1_cur_d;
      s2_cur_q <= s2_cur_d;
    end
  end

  assign force_glyph = s2_cur_q;
`else
  logic unused_cursor;
  assign unused_cursor = ^{cur_col, cur_row};
  assign force_glyph   = 1'b0;
`endif

  assign rom_addr   = {buf_q[15:8], s1_yrow_q};
  assign rgb_out    = rgb_q;
  assign hsync_out  = hs_q;
  assign vsync_out  = vs_q;
  assign active_out = act_q;

endmodule

// File: doc/text_glyph_renderer.md
Name: text_glyph_renderer

Overview:
- Text-mode rendering stage directly downstream of the AXI4-Lite character ROM controller registers.
- Register-side writes place characters and attributes into an internal text buffer.
- A 3-stage pixel pipeline converts incoming VGA pixel coordinates into 12-bit RGB using the external character ROM and a fixed 16-colour palette.
- Sits between the register block and the VGA output pins.

Parameters:
- COLS, 80, text columns.
- ROWS, 30, text rows.
- GLYPH_W, 8, glyph width in pixels (fixed 8; ROM row byte).
- GLYPH_H, 16, glyph height in pixels; ROM rows per character.
- CLR_ATTR, 8'h07, attribute written by clear (bg 0, fg 7).

Ports:
- ACLK  in  1  pixel/system clock.
- ARESET  in  1  asynchronous, active-high reset.
- wr_valid  in  1  register-side write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_col  in  7  target column.
- wr_row  in  5  target row.
- wr_char  in  8  character code.
- wr_attr  in  8  [7:4] bg index, [3:0] fg index.
- wr_err  out  1  1-cycle pulse: accepted write was out of range.
- clr_start  in  1  pulse; fill buffer with 0x20 / CLR_ATTR.
- clr_busy  out  1  high while clearing.
- pix_x  in  10  current pixel column.
- pix_y  in  10  current pixel row.
- pix_active  in  1  display-enable from timing generator.
- pix_hsync  in  1  hsync from timing generator.
- pix_vsync  in  1  vsync from timing generator.
- rom_addr  out  12  {char, glyph_row[3:0]} to char ROM.
- rom_data  in  8  glyph row; valid 1 cycle after rom_addr; bit 7 = leftmost pixel.
- cur_col  in  7  cursor column (used only with the optional feature).
- cur_row  in  5  cursor row (used only with the optional feature).
- rgb_out  out  12  {R4,G4,B4}.
- hsync_out  out  1  delayed hsync.
- vsync_out  out  1  delayed vsync.
- active_out  out  1  delayed display-enable.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, pipeline registers cleared. Text buffer contents are not reset.
- Text buffer: COLS*ROWS entries x 16 bits {char, attr}; address = row*COLS + col. One write port, one synchronous read port. Read-first on same-address collision (old data returned).
- FSM states:
  - IDLE: clr_start -> CLEAR with ptr=0. Else accept writes.
  - CLEAR: write {8'h20, CLR_ATTR} at ptr each cycle; ptr++; at ptr == COLS*ROWS-1 -> IDLE. Takes exactly 2400 cycles at defaults.
- wr_ready = (state == IDLE) && !clr_start. clr_start wins over a simultaneous write; that write is not accepted. clr_busy = (state == CLEAR). clr_start during CLEAR is ignored.
- Out-of-range write (wr_col >= COLS or wr_row >= ROWS): accepted, buffer unchanged, wr_err pulses the next cycle.
- Reset mid-CLEAR: abort to IDLE; buffer contents partially cleared/undefined.
- Pipeline (latency exactly 3 cycles, fully pipelined, one pixel per cycle):
  - C0: register pix_x, pix_y, sync/active; compute cell col = pix_x/8, row = pix_y/16, read buffer.
  - C1: buffer data valid; drive registered rom_addr = {char, pix_y[3:0]}; carry attr and pix_x[2:0].
  - C2: rom_data valid; bit = rom_data[7 - xbit].
  - C3 (outputs registered): rgb_out = palette(bit ? fg : bg).
- rgb_out = 0 when the delayed active is 0, or when pixel is outside the text area (x >= COLS*8 or y >= ROWS*16).
- hsync_out, vsync_out, active_out = inputs delayed exactly 3 cycles.
- Palette (index -> RGB): 0 000, 1 00A, 2 0A0, 3 0AA, 4 A00, 5 A0A, 6 A50, 7 AAA, 8 555, 9 55F, A 5F5, B 5FF, C F55, D F5F, E FF5, F FFF.
- Writes and clears proceed concurrently with rendering; no stalls on the pixel side.

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- Defined:
  - 5-bit frame counter increments on each vsync rising edge; cursor is visible while counter[4] = 1 (toggles every 16 frames).
  - When visible, in cell (cur_col, cur_row), glyph rows 14-15 are forced to 8'hFF (all fg).
  - Counter resets to 0.
- Undefined: cur_col/cur_row are ignored; no counter logic is present.

Test Plan:
- Reset: assert ARESET mid-stream -> rgb_out=000, all syncs 0, wr_ready=1 one cycle after release.
- Write col 0, row 0, char 0x41, attr 0x1F; ROM model 'A' row 0 = 0x18; render y=0, x=0..7 -> rgb 00A,00A,00A,FFF,FFF,00A,00A,00A, each 3 cycles after input.
- Out-of-range: write col 80, row 0 -> wr_ready=1, wr_err pulses once, a readback render of cell (79,0) is unchanged.
- Clear: clr_start together with wr_valid -> write not taken, clr_busy high 2400 cycles, then every cell reads 0x20/0x07 (rgb 000 on blank glyph).
- Sync alignment: pix_hsync toggled at cycle N -> hsync_out toggles at N+3; pixel x=640 with active=1 -> rgb 000.
- CURSOR_BLINK_EN: cursor at (2,1), 16 vsync edges -> rows 30-31, x=16..23 output fg colour; after 32 edges -> normal glyph.
